// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
//   Stall vectors: bit 0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W  = 6;
  localparam int unsigned WORD_W   = 32;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  localparam logic FLUSH_ENABLE  = 1'b1;
  localparam logic FLUSH_DISABLE = 1'b0;

  localparam logic [WORD_W-1:0] ZERO_WORD   = 32'h0000_0000;
  localparam logic [WORD_W-1:0] BUS_ERR_VEC = 32'h0000_0040;

  typedef enum logic {
    CTRL_RUN   = 1'b0,
    CTRL_FLUSH = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear
//   inc      : add one unless already all ones
//   count    : current value
module pipe_ctrl_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall arbitration, exception/bus-timeout flush
// sequencing and a saturating stall-cycle counter.
//   clk, rst                 : clock, synchronous active-high reset
//   stallreq_id/ex/mem       : stall requests (priority MEM > EX > ID)
//   except_valid, except_pc  : exception/ERET commit and its target PC
//   stall                    : combinational per-stage stall vector
//   flush, new_pc, bus_err   : registered flush control and timeout pulse
//   stall_cycles             : saturating count of stalled cycles
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned       FLUSH_CYCLES = 1,
  parameter int unsigned       TIMEOUT      = 256,
  parameter logic [31:0]       BUS_ERR_PC   = BUS_ERR_VEC,
  parameter int unsigned       CNT_W        = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        except_valid,
  input  logic [31:0] except_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        bus_err,
  output logic [31:0] stall_cycles
);

  localparam int unsigned TCNT_W = 16;
  localparam int unsigned FCNT_W = 4;

  ctrl_state_t        state_q, state_d;
  logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic               flush_d, bus_err_d;
  logic [31:0]        new_pc_d;
  logic               exc_take, tmo_fire, flush_done;
  logic [CNT_W-1:0]   stall_cnt;

  assign exc_take   = (state_q == CTRL_RUN) && except_valid;
  assign tmo_fire   = (state_q == CTRL_RUN) && stallreq_mem &&
                      (tcnt_q == TCNT_W'(TIMEOUT - 1));
  assign flush_done = (state_q == CTRL_FLUSH) &&
                      (fcnt_q == FCNT_W'(FLUSH_CYCLES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= CTRL_RUN;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      CTRL_RUN:   if (exc_take || tmo_fire) state_d = CTRL_FLUSH;
      CTRL_FLUSH: if (flush_done)           state_d = CTRL_RUN;
      default:    state_d = CTRL_RUN;
    endcase
  end

  // Output logic: combinational stall plus next values of registered outputs
  always_comb begin
    stall     = STALL_NONE;
    flush_d   = (state_d == CTRL_FLUSH) ? FLUSH_ENABLE : FLUSH_DISABLE;
    bus_err_d = tmo_fire && !except_valid;
    new_pc_d  = new_pc;
    if (!rst && (state_q == CTRL_RUN) && !except_valid) begin
      if      (stallreq_mem) stall = STALL_MEM;
      else if (stallreq_ex)  stall = STALL_EX;
      else if (stallreq_id)  stall = STALL_ID;
    end
    // Exception outranks a coincident timeout
    if (exc_take)      new_pc_d = except_pc;
    else if (tmo_fire) new_pc_d = BUS_ERR_PC;
  end

  // Timeout and flush-length counters
  always_comb begin
    tcnt_d = '0;
    fcnt_d = '0;
    if ((state_q == CTRL_RUN) && stallreq_mem && !except_valid && !tmo_fire)
      tcnt_d = tcnt_q + TCNT_W'(1);
    if ((state_q == CTRL_FLUSH) && !flush_done)
      fcnt_d = fcnt_q + FCNT_W'(1);
  end

  // Registered outputs and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      flush   <= FLUSH_DISABLE;
      new_pc  <= ZERO_WORD;
      bus_err <= 1'b0;
      tcnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      flush   <= flush_d;
      new_pc  <= new_pc_d;
      bus_err <= bus_err_d;
      tcnt_q  <= tcnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  pipe_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (stall != STALL_NONE),
    .count (stall_cnt)
  );

  assign stall_cycles = 32'(stall_cnt);

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit for the 5-stage integer core. It arbitrates stall requests from ID, EX and MEM into the per-stage stall vector used by pc_reg, if_id, id_ex, ex_mem and mem_wb. It sequences pipeline flushes on exceptions and ERET, and on a MEM bus-wait timeout. It also keeps a saturating stall-cycle performance counter.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles flush is held (1..15)
TIMEOUT, 256, consecutive stallreq_mem cycles that trigger a bus-error flush (2..65535)
BUS_ERR_VEC, 32'h0000_0040, new_pc issued on bus-error flush

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high (`RstEnable)
stallreq_id  in  1  load-use hazard stall request from ID
stallreq_ex  in  1  multi-cycle mult/div stall request from EX
stallreq_mem  in  1  data-bus wait request from MEM
except_valid  in  1  exception or ERET committed in MEM this cycle
except_pc  in  32 (`RegBus)  target PC for except_valid (vector or EPC)
stall  out  6  stall[0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB
flush  out  1  clear all pipeline registers to NOP
new_pc  out  32  PC to load while flush=1
bus_err  out  1  one-cycle pulse: bus-wait timeout fired
stall_cycles  out  32  saturating count of cycles with stall!=0

Behaviour:
- Reset (rst=1 at posedge): state=RUN, flush=0, new_pc=`ZeroWord, bus_err=0, stall_cycles=0, timeout counter=0, flush counter=0. stall is combinational and evaluates to 0 while rst=1.
- FSM states:
  - RUN: normal operation.
  - FLUSH: flush held; lasts exactly FLUSH_CYCLES cycles, then the FSM returns to RUN.
- stall (combinational, RUN only), priority MEM > EX > ID:
  - stallreq_mem -> 6'b011111
  - else stallreq_ex -> 6'b001111
  - else stallreq_id -> 6'b000111
  - else 6'b000000
- stall is 6'b000000 in FLUSH, and in any RUN cycle with except_valid=1 (the exception overrides all stall requests).
- Exception: except_valid=1 in RUN at cycle N →
  - state=FLUSH from N+1.
  - flush=1 and new_pc=except_pc (registered at N) for cycles N+1..N+FLUSH_CYCLES.
  - flush=0 at N+FLUSH_CYCLES+1.
- except_valid is ignored while in FLUSH; new_pc holds its value.
- Timeout counter: increments each RUN cycle with stallreq_mem=1 and except_valid=0. It clears when stallreq_mem=0, on entry to FLUSH, and on rst.
- Timeout fire: when the counter reaches TIMEOUT-1 and stallreq_mem is still 1 (i.e. the TIMEOUT-th consecutive cycle) →
  - next cycle: state=FLUSH, new_pc=BUS_ERR_VEC, flush=1, bus_err=1 for exactly one cycle.
- Simultaneous except_valid and timeout fire: the exception wins. new_pc=except_pc, bus_err stays 0, counter clears.
- stall_cycles: +1 on every cycle where the stall output is non-zero; saturates at 32'hFFFF_FFFF.
- flush, new_pc and bus_err are registered outputs (latency 1 from the cause).
- rst asserted during FLUSH: returns to RUN next cycle with flush=0, abandoning the remaining flush cycles.

Decomposition:
- Shared defines header gets:
  - `StallNone/`StallId/`StallEx/`StallMem vectors (6'b000000/000111/001111/011111)
  - `FlushEnable/`FlushDisable
  - `BusErrVec
  - state encodings `CtrlRun/`CtrlFlush
- One sub-module is natural: sat_counter (parameterised width, inc, clr, saturate), instantiated for stall_cycles.
- The timeout and flush counters stay inline.

Test Plan:
- rst=1 for 2 cycles with all requests high → stall=0, flush=0, new_pc=0, stall_cycles=0; after release, stallreq_id=1 → stall=6'b000111.
- stallreq_id=stallreq_ex=stallreq_mem=1 for 3 cycles → stall=6'b011111 each cycle, stall_cycles=3.
- except_valid=1, except_pc=32'h0000_0020, with stallreq_ex=1, FLUSH_CYCLES=2 → stall=0 that cycle; flush=1, new_pc=32'h20 for the next 2 cycles; flush=0 after. A second except_valid during FLUSH has no effect.
- stallreq_mem held 256 cycles (TIMEOUT=256) → bus_err=1 and flush=1, new_pc=32'h40 on cycle 257. Held 255 cycles then dropped → no flush, counter cleared.
- except_valid coinciding with the 256th stallreq_mem cycle → new_pc=except_pc, bus_err=0.
- Force stall_cycles near 32'hFFFF_FFFF (TIMEOUT raised to maximum, long stallreq_id) → saturates at all ones, no wrap. rst mid-FLUSH → flush=0 next cycle, state RUN.
